// File: rtl/odu_err_inject.sv
// Registered, armed, channel-targeted error injector for the ODU test path (single/burst/periodic).
// Optional LFSR data corruption is enabled with `define ODU_ERR_INJ_LFSR_EN; default forces data to zero.
module odu_err_inject #(
    parameter int DATA_W = 384,
    parameter int CHID_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_fs,
    input  logic              i_rs,
    input  logic [7:0]        i_mfas,
    input  logic [CHID_W-1:0] i_chid,
    input  logic [1:0]        i_mode,
    input  logic [4:0]        i_err_mask,
    input  logic [CHID_W-1:0] i_target_chid,
    input  logic              i_chid_match_en,
    input  logic [CNT_W-1:0]  i_burst_len,
    input  logic [CNT_W-1:0]  i_period,
    input  logic              i_arm,
    input  logic              i_stop,
    input  logic              i_cnt_clr,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_fs,
    output logic              o_rs,
    output logic [7:0]        o_mfas,
    output logic [CHID_W-1:0] o_chid,
    output logic              o_inj,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_inj_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, PERIODIC = 2'd2} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + ONE;
    endfunction

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] c);
        return (c == '0) ? ONE : c;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [4:0]         mask_q, mask_d;
    logic [CHID_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qual, inj;
    logic [DATA_W-1:0]  data_d;

`ifdef ODU_ERR_INJ_LFSR_EN
    localparam logic [31:0] SEED = 32'hACE1_0001;
    logic [31:0] lfsr_q, lfsr_d;

    // x^32+x^22+x^2+x+1, taps at bits 31,21,1,0
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_pat(input logic [31:0] s);
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W; i++) p[i] = s[i % 32];
        return p;
    endfunction

    assign lfsr_d = inj ? lfsr_next(lfsr_q) : lfsr_q;
    assign data_d = (inj && mask_q[3]) ? (i_data ^ lfsr_pat(lfsr_q)) : i_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign data_d = (inj && mask_q[3]) ? '0 : i_data;
`endif

    always_comb begin
        qual = i_valid && (!i_chid_match_en || (i_chid == tgt_q));
        inj  = 1'b0;
        if (!i_stop) begin
            case (state_q)
                ARMED:    inj = qual;
                PERIODIC: inj = qual && ((pcnt_q + ONE) == at_least_one(period_q));
                default:  inj = 1'b0;
            endcase
        end

        state_d  = state_q;
        remain_d = remain_q;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        mask_d   = mask_q;
        tgt_d    = tgt_q;
        if (i_stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_arm && (i_mode != 2'd0)) begin
                        mask_d   = i_err_mask;
                        tgt_d    = i_target_chid;
                        period_d = i_period;
                        if (i_mode == 2'd3) begin
                            state_d = PERIODIC;
                            pcnt_d  = '0;
                        end else begin
                            state_d  = ARMED;
                            remain_d = (i_mode == 2'd1) ? ONE : at_least_one(i_burst_len);
                        end
                    end
                end
                ARMED: begin
                    if (qual) begin
                        remain_d = remain_q - ONE;
                        if (remain_q == ONE) state_d = IDLE;
                    end
                end
                PERIODIC: begin
                    if (qual) pcnt_d = inj ? '0 : pcnt_q + ONE;
                end
                default: state_d = IDLE;
            endcase
        end

        // a clear coinciding with an injection still counts that injection
        cnt_d = cnt_q;
        if (inj)            cnt_d = i_cnt_clr ? ONE : sat_inc(cnt_q);
        else if (i_cnt_clr) cnt_d = '0;
    end

    // output register stage: stream and injection flag leave together, one cycle after input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            pcnt_q    <= '0;
            period_q  <= '0;
            mask_q    <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_fs      <= 1'b0;
            o_rs      <= 1'b0;
            o_mfas    <= 8'h00;
            o_chid    <= '0;
            o_inj     <= 1'b0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            pcnt_q    <= pcnt_d;
            period_q  <= period_d;
            mask_q    <= mask_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            o_valid   <= i_valid ^ (inj & mask_q[4]);
            o_data    <= data_d;
            o_fs      <= i_fs ^ (inj & mask_q[2]);
            o_rs      <= i_rs ^ (inj & mask_q[1]);
            o_mfas    <= (inj && mask_q[0]) ? 8'hFF : i_mfas;
            o_chid    <= i_chid;
            o_inj     <= inj;
        end
    end

    assign o_busy    = (state_q != IDLE);
    assign o_inj_cnt = cnt_q;

endmodule

// File: tb/tb_odu_err_inject.sv
// Scoreboard bench for odu_err_inject: a behavioural model pushes expected beats, the output side pops them.
module tb_odu_err_inject;

    localparam int DW = 64;
    localparam int CW = 7;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 0, i_fs = 0, i_rs = 0;
    logic [DW-1:0] i_data = '0;
    logic [7:0]    i_mfas = '0;
    logic [CW-1:0] i_chid = '0, i_target_chid = '0;
    logic [1:0]    i_mode = '0;
    logic [4:0]    i_err_mask = '0;
    logic          i_chid_match_en = 0, i_arm = 0, i_stop = 0, i_cnt_clr = 0;
    logic [NW-1:0] i_burst_len = '0, i_period = '0;
    logic          o_valid, o_fs, o_rs, o_inj, o_busy;
    logic [DW-1:0] o_data;
    logic [7:0]    o_mfas;
    logic [CW-1:0] o_chid;
    logic [NW-1:0] o_inj_cnt;

    odu_err_inject #(.DATA_W(DW), .CHID_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_fs(i_fs), .i_rs(i_rs),
        .i_mfas(i_mfas), .i_chid(i_chid), .i_mode(i_mode), .i_err_mask(i_err_mask),
        .i_target_chid(i_target_chid), .i_chid_match_en(i_chid_match_en),
        .i_burst_len(i_burst_len), .i_period(i_period), .i_arm(i_arm), .i_stop(i_stop),
        .i_cnt_clr(i_cnt_clr), .o_valid(o_valid), .o_data(o_data), .o_fs(o_fs), .o_rs(o_rs),
        .o_mfas(o_mfas), .o_chid(o_chid), .o_inj(o_inj), .o_busy(o_busy), .o_inj_cnt(o_inj_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] data;
        logic          fs;
        logic          rs;
        logic [7:0]    mfas;
        logic [CW-1:0] chid;
        logic          inj;
        logic          busy;
        logic [NW-1:0] cnt;
    } beat_t;

    beat_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    inj_seen = 0;

    // model state: 0 idle, 1 armed, 2 periodic
    int          m_state, m_remain, m_pcnt, m_period, m_cnt;
    logic [4:0]  m_mask;
    logic [CW-1:0] m_tgt;
    logic [31:0] m_lfsr;

    task automatic model_reset();
        m_state = 0; m_remain = 0; m_pcnt = 0; m_period = 0; m_cnt = 0;
        m_mask = '0; m_tgt = '0; m_lfsr = 32'hACE1_0001;
        sb_q.delete();
    endtask

    // drive one beat at the falling edge, predict, then compare just after the rising edge
    task automatic step(input logic v, input logic [CW-1:0] ch, input logic arm,
                        input logic stop, input logic clr);
        beat_t e, a;
        logic  qual, inj;
        logic [DW-1:0] pat;
        i_valid = v; i_chid = ch; i_arm = arm; i_stop = stop; i_cnt_clr = clr;
        i_data = {$urandom, $urandom};
        i_fs = 1'($urandom); i_rs = 1'($urandom); i_mfas = 8'($urandom_range(0, 254));

        qual = v && (!i_chid_match_en || ch == m_tgt);
        inj = 1'b0;
        if (!stop && m_state == 1) inj = qual;
        if (!stop && m_state == 2) inj = qual && (m_pcnt + 1 == ((m_period == 0) ? 1 : m_period));
        for (int i = 0; i < DW; i++) pat[i] = m_lfsr[i % 32];
        e.valid = v ^ (inj & m_mask[4]);
`ifdef ODU_ERR_INJ_LFSR_EN
        e.data  = (inj && m_mask[3]) ? (i_data ^ pat) : i_data;
`else
        e.data  = (inj && m_mask[3]) ? '0 : i_data;
`endif
        e.fs   = i_fs ^ (inj & m_mask[2]);
        e.rs   = i_rs ^ (inj & m_mask[1]);
        e.mfas = (inj && m_mask[0]) ? 8'hFF : i_mfas;
        e.chid = ch;
        e.inj  = inj;

        if (stop) m_state = 0;
        else if (m_state == 0) begin
            if (arm && i_mode != 0) begin
                m_mask = i_err_mask; m_tgt = i_target_chid; m_period = int'(i_period);
                if (i_mode == 3) begin m_state = 2; m_pcnt = 0; end
                else begin
                    m_state = 1;
                    m_remain = (i_mode == 1) ? 1 : ((i_burst_len == 0) ? 1 : int'(i_burst_len));
                end
            end
        end else if (m_state == 1) begin
            if (qual) begin m_remain--; if (m_remain == 0) m_state = 0; end
        end else if (qual) m_pcnt = inj ? 0 : m_pcnt + 1;
        if (inj) begin
            m_cnt  = clr ? 1 : ((m_cnt == 15) ? 15 : m_cnt + 1);
            m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
        end else if (clr) m_cnt = 0;
        e.busy = (m_state != 0);
        e.cnt  = NW'(m_cnt);
        sb_q.push_back(e);

        @(posedge clk); #1;
        a = {o_valid, o_data, o_fs, o_rs, o_mfas, o_chid, o_inj, o_busy, o_inj_cnt};
        e = sb_q.pop_front();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL beat t=%0t got=%h want=%h", $time, a, e);
        end
        if (o_inj === 1'b1) inj_seen++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({o_valid, o_data, o_fs, o_rs, o_mfas, o_chid, o_inj, o_busy, o_inj_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=0", {o_valid, o_data, o_mfas, o_inj_cnt});
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        inj_seen = 0;
        i_mode = 2'd0;
        for (int i = 0; i < 6; i++) step(1'(i % 2), 7'(i), 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (inj_seen != 0 || o_inj_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL off_mode inj=%0d cnt=%0d want 0/0", inj_seen, o_inj_cnt);
        end
    endtask

    task automatic test_single();
        i_mode = 2'd1; i_err_mask = 5'b00100; i_chid_match_en = 1; i_target_chid = 7'd5;
        inj_seen = 0;
        step(1, 7'd5, 1, 0, 0);
        step(1, 7'd3, 0, 0, 0);
        step(1, 7'd5, 0, 0, 0);
        step(1, 7'd5, 0, 0, 0);
        n_cmp++;
        if (inj_seen != 1 || o_busy !== 1'b0 || o_inj_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL single inj=%0d busy=%b cnt=%0d want 1/0/1", inj_seen, o_busy, o_inj_cnt);
        end
    endtask

    task automatic test_burst();
        i_mode = 2'd2; i_burst_len = 4'd3; i_err_mask = 5'b00001; i_chid_match_en = 0;
        inj_seen = 0;
        step(1, 7'd1, 1, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 7'(i + 20), 0, 0, 0);
        n_cmp++;
        if (inj_seen != 3 || o_inj_cnt !== 4'd3) begin
            n_bad++;
            $display("FAIL burst3 inj=%0d cnt=%0d want 3/3", inj_seen, o_inj_cnt);
        end
        i_burst_len = 4'd0;
        inj_seen = 0;
        step(1, 7'd1, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 7'(i), 0, 0, 0);
        n_cmp++;
        if (inj_seen != 1 || o_inj_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL burst0 inj=%0d cnt=%0d want 1/1", inj_seen, o_inj_cnt);
        end
    endtask

    task automatic test_periodic();
        i_mode = 2'd3; i_period = 4'd4; i_err_mask = 5'b01000; i_chid_match_en = 1;
        i_target_chid = 7'd9;
        inj_seen = 0;
        step(1, 7'd9, 1, 0, 1);
        for (int i = 1; i <= 21; i++) step(1, 7'd9, 0, 0, 0);
        step(1, 7'd9, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 7'd9, 0, 0, 0);
        n_cmp++;
        if (inj_seen != 5 || o_busy !== 1'b0 || o_inj_cnt !== 4'd5) begin
            n_bad++;
            $display("FAIL periodic inj=%0d busy=%b cnt=%0d want 5/0/5", inj_seen, o_busy, o_inj_cnt);
        end
    endtask

    task automatic test_edges();
        i_mode = 2'd2; i_burst_len = 4'd5; i_err_mask = 5'b10110; i_chid_match_en = 0;
        step(1, 7'd2, 1, 1, 0);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL arm_with_stop busy=%b want 0", o_busy);
        end
        inj_seen = 0;
        step(1, 7'd2, 1, 0, 1);
        step(1, 7'd2, 0, 0, 0);
        i_mode = 2'd1;
        step(1, 7'd2, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 7'd2, 0, 0, 0);
        n_cmp++;
        if (inj_seen != 5 || o_inj_cnt !== 4'd5) begin
            n_bad++;
            $display("FAIL arm_while_busy inj=%0d cnt=%0d want 5/5", inj_seen, o_inj_cnt);
        end
        i_mode = 2'd2; i_burst_len = 4'd2;
        step(1, 7'd4, 1, 0, 0);
        step(1, 7'd4, 0, 0, 1);
        n_cmp++;
        if (o_inj_cnt !== 4'd1 || o_inj !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_with_inj cnt=%0d inj=%b want 1/1", o_inj_cnt, o_inj);
        end
        step(1, 7'd4, 0, 0, 0);
        i_burst_len = 4'd15;
        step(1, 7'd4, 1, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 7'd4, 0, 0, 0);
        i_mode = 2'd1;
        step(1, 7'd4, 1, 0, 0);
        step(1, 7'd4, 0, 0, 0);
        n_cmp++;
        if (o_inj_cnt !== 4'hF) begin
            n_bad++;
            $display("FAIL saturate cnt=%0d want 15", o_inj_cnt);
        end
    endtask

    task automatic test_rst_mid();
        i_mode = 2'd2; i_burst_len = 4'd4; i_err_mask = 5'b11111; i_chid_match_en = 0;
        step(1, 7'd6, 1, 0, 1);
        step(1, 7'd6, 0, 0, 0);
        step(1, 7'd6, 0, 0, 0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_valid, o_data, o_fs, o_rs, o_mfas, o_chid, o_inj, o_busy, o_inj_cnt} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid got=%h want=0", {o_valid, o_data, o_mfas, o_inj, o_busy, o_inj_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        inj_seen = 0;
        for (int i = 0; i < 4; i++) step(1, 7'd6, 0, 0, 0);
        n_cmp++;
        if (inj_seen != 0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL after_rst inj=%0d busy=%b want 0/0", inj_seen, o_busy);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_periodic();
        test_edges();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/odu_err_inject.md
# odu_err_inject

Parametrised, registered error injector for the ODU test path, placed between the ODU frame generator output and the ODU checker input. It replaces the fixed, level-driven corruption of valid/data/FS/RS/MFAS with armed, channel-targeted injection in single, burst and periodic modes. It also provides an injection counter, so the bench can reconcile injected errors against the checker's per-channel error flags.

## Interface
Parameters:
- DATA_W, 384, payload width
- CHID_W, 7, channel-ID width
- CNT_W, 16, width of burst length, period and injection counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input beat valid
- i_data  in  DATA_W  input payload
- i_fs  in  1  frame-start marker
- i_rs  in  1  row-start marker
- i_mfas  in  8  multiframe alignment signal
- i_chid  in  CHID_W  channel of the current beat
- i_mode  in  2  0 OFF, 1 SINGLE, 2 BURST, 3 PERIODIC
- i_err_mask  in  5  bit 4 valid, bit 3 data, bit 2 fs, bit 1 rs, bit 0 mfas
- i_target_chid  in  CHID_W  channel to corrupt
- i_chid_match_en  in  1  1: only beats on i_target_chid qualify; 0: any valid beat qualifies
- i_burst_len  in  CNT_W  beats to corrupt in BURST mode
- i_period  in  CNT_W  qualifying-beat period in PERIODIC mode
- i_arm  in  1  one-cycle start pulse
- i_stop  in  1  one-cycle abort pulse
- i_cnt_clr  in  1  clear the injection counter
- o_valid, o_data, o_fs, o_rs, o_mfas, o_chid  out  same widths as inputs  registered, possibly corrupted stream
- o_inj  out  1  high with an output beat that was corrupted
- o_busy  out  1  FSM not in IDLE
- o_inj_cnt  out  CNT_W  total corrupted beats, saturating

## Operation
- Qualifying beat: i_valid=1 AND (i_chid_match_en=0 OR i_chid==i_target_chid).
- Corruption applied to a qualifying beat:
  - valid inverted
  - data per Configuration
  - fs inverted
  - rs inverted
  - mfas forced to 8'hFF
  - Each item applies only if its mask bit is set. Non-qualifying beats pass unchanged.
- The beat is flagged (o_inj=1, counter incremented) even when i_err_mask=0.
- The mode, mask, target, burst length and period are captured into shadow registers on an accepted i_arm. Later input changes are ignored until the FSM returns to IDLE.
- FSM states: IDLE, ARMED, PERIODIC.
  - IDLE: i_arm with i_mode=1 or 2 goes to ARMED and loads remain = 1 (SINGLE) or max(i_burst_len,1) (BURST). i_arm with i_mode=3 goes to PERIODIC with pcnt=0. i_arm with i_mode=0 is ignored.
  - ARMED: each qualifying beat is corrupted and decrements remain. When remain reaches 0, go to IDLE.
  - PERIODIC: each qualifying beat increments pcnt. When pcnt+1 equals max(period,1), the beat is corrupted and pcnt returns to 0. This mode runs until i_stop.
- i_arm while busy is ignored.
- i_stop in any state goes to IDLE, and the beat in that same cycle is not corrupted. If i_stop and i_arm are asserted together, i_stop wins.
- o_inj_cnt increments once per corrupted beat and holds at all-ones. If i_cnt_clr and an injection coincide, the counter is loaded with 1.

## Timing
- Data path latency is exactly 1 cycle: output registers sample the inputs and the corruption decision from the same cycle. o_chid and o_inj are aligned with o_data.
- The injection decision uses the current-cycle FSM state, so a qualifying beat in the cycle i_arm is sampled is not corrupted. The earliest corrupted beat is the cycle after i_arm.
- No back-pressure: a beat is accepted every cycle.
- Reset values: all outputs 0 (o_mfas=8'h00), FSM IDLE, all counters and shadow registers 0. Reset asserted mid-burst or mid-period aborts immediately with no residual injection.

## Configuration
- ODU_ERR_INJ_LFSR_EN defined:
  - Data corruption is o_data = i_data XOR lfsr, where lfsr is a DATA_W-bit pattern from a 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1, seed 32'hACE1_0001, replicated across width).
  - The LFSR advances once per corrupted beat and resets to the seed.
- ODU_ERR_INJ_LFSR_EN undefined:
  - Data corruption forces o_data to all zeros.
  - No LFSR logic is present.

## Test plan
- Reset release with i_valid toggling and mode OFF -> outputs equal inputs delayed 1 cycle; o_inj=0; o_inj_cnt=0.
- SINGLE, mask 5'b00100, match_en=1, target=5, beats on chid 3,5,5 -> only the first chid-5 beat has fs inverted and o_inj=1; o_busy falls after it; o_inj_cnt=1.
- BURST, burst_len=3, mask 5'b00001, match_en=0, 10 consecutive valid beats -> beats 1-3 after arm have o_mfas=8'hFF; o_inj_cnt=3; burst_len=0 variant corrupts exactly 1 beat.
- PERIODIC, period=4, mask 5'b01000, 20 qualifying beats -> beats 4, 8, 12, 16, 20 corrupted (data zero, or XOR-pattern with the macro defined); i_stop on beat 22 -> no further injection, o_busy=0.
- Edge cases:
  - i_arm together with i_stop -> stays IDLE.
  - i_arm while BURST is active -> ignored.
  - Counter preloaded near all-ones -> saturates.
  - i_cnt_clr coincident with an injection -> o_inj_cnt=1.
- rst asserted mid-burst with remain=2 -> all outputs 0 asynchronously; after release, no injection until a new i_arm.
